unified_mem_arbiter: RTL and testbench
======================================

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter `AW`, default 32: width of all address ports.
REQ-002 Parameter `DW`, default 32: width of all data ports.
REQ-003 Parameter `STARVE_MAX`, default 4: maximum number of consecutive data grants while a fetch is pending.
REQ-004 Parameter `TIMEOUT`, default 255: number of access cycles without `mem_ack` before a timeout.
REQ-005 Ports, one per line (name, direction, width, meaning):
- `clock` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request from the IF stage.
- `if_addr` in AW: fetch address.
- `if_rdata` out DW: fetched instruction.
- `if_ready` out 1: one-cycle pulse marking fetch completion.
- `dm_req` in 1: data request from the MEM stage.
- `dm_we` in 1: data access is a store (1) or a load (0).
- `dm_addr` in AW: data address.
- `dm_wdata` in DW: store data.
- `dm_rdata` out DW: load data.
- `dm_ready` out 1: one-cycle pulse marking data completion.
- `stall` out 1: pipeline freeze request.
- `mem_req` out 1: access request to the shared single-port memory.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_ack` in 1: memory completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in DW: memory read data.
- `timeout_err` out 1: sticky memory-timeout flag.

Function
REQ-006 FSM states: IDLE, IF_ACC, DM_ACC, DONE; all state, counters and outputs other than `stall` are registered.
REQ-007 IDLE, transitions:
- `dm_req`=1 and `if_req`=0 -> DM_ACC.
- `if_req`=1 and `dm_req`=0 -> IF_ACC.
- Both set -> DM_ACC, except when starve_cnt==`STARVE_MAX` -> IF_ACC.
REQ-008 starve_cnt updates:
- Increments on every DM grant made while `if_req`=1.
- Clears on every IF grant.
- Saturates at `STARVE_MAX`.
REQ-009 On entering IF_ACC or DM_ACC, `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are loaded from the granted port; they hold stable until `mem_ack` is sampled high.
REQ-010 In IF_ACC, `mem_we` is 0 and `mem_wdata` is 0.
REQ-011 In an ACC state with `mem_ack`=1:
- `mem_req` drops at the next edge.
- A load or fetch captures `mem_rdata` into `dm_rdata` or `if_rdata`.
- The FSM moves to DONE.
REQ-012 DONE lasts exactly one cycle, pulses the matching `if_ready` or `dm_ready`, then returns to IDLE; the new request is sampled in IDLE.
REQ-013 Minimum latency: request sampled at edge N; `mem_req` is high in cycle N+1; with `mem_ack` in N+1, ready is high in N+2.
REQ-014 `if_rdata` and `dm_rdata` hold their last captured value until the next completed access on that port; a store leaves `dm_rdata` unchanged.
REQ-015 `stall` = (`if_req` & ~`if_ready`) | (`dm_req` & ~`dm_ready`), combinational.
REQ-016 A requester holds its req and operands stable until its ready pulse; a req still high in the cycle after ready is a new access.
REQ-017 `mem_ack` is ignored while `mem_req`=0; `if_ready` and `dm_ready` are never high in the same cycle.

Reset
REQ-018 `reset`=0 immediately forces, regardless of clock:
- FSM to IDLE.
- `mem_req`, `mem_we`, `if_ready`, `dm_ready` to 0.
- `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` to 0.
- starve_cnt, timeout counter and `timeout_err` to 0.
REQ-019 Reset during IF_ACC, DM_ACC or DONE abandons the access with no ready pulse; the first grant after release follows REQ-007.

Configuration
REQ-020 Macro `ARB_TIMEOUT_EN` defined:
- A counter clears on entering an ACC state and increments each ACC cycle without `mem_ack`.
- When it reaches `TIMEOUT`, the access completes as if acked with read data 32'h0 (a NOP for fetches), and `timeout_err` is set.
- `timeout_err` stays set until reset.
REQ-021 `ARB_TIMEOUT_EN` undefined: no counter is built, an access waits indefinitely for `mem_ack`, and `timeout_err` is tied to 0.

Verification
REQ-022 `if_req`=1, `if_addr`=0x0040_0000, `mem_ack` in the first `mem_req` cycle returning 0x2008_0005 -> `if_ready` pulses 2 cycles after sampling, `if_rdata`=0x2008_0005.
REQ-023 `if_req` and `dm_req` both high (load, addr 0x1001_0000) -> DM served first with `mem_we`=0, then IF; `stall` stays 1 until `if_ready`.
REQ-024 `dm_req` held high for back-to-back stores alongside a constant `if_req` -> an IF grant occurs after exactly 4 DM grants.
REQ-025 Store addr 0x1001_0004, data 0xDEAD_BEEF, `mem_ack` after 3 wait cycles -> `mem_we`=1 with stable addr/data for 4 cycles, `dm_rdata` unchanged.
REQ-026 `reset` pulled low mid-DM_ACC -> `mem_req`=0 asynchronously, no `dm_ready`; after release, a pending `if_req` is granted.
REQ-027 With `ARB_TIMEOUT_EN`, `mem_ack` held at 0 on a fetch -> `if_ready` after 255 access cycles, `if_rdata`=0, `timeout_err`=1 until reset.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port memory between the instruction-fetch (IF) and
// data-memory (MEM) pipeline stages. Data accesses win ties, but after
// STARVE_MAX consecutive data grants with a fetch waiting, the fetch is served.
// Optional feature: define ARB_TIMEOUT_EN to build an access watchdog that
// completes a stuck access after TIMEOUT cycles with zero read data and sets
// the sticky timeout_err flag. Without it, accesses wait for mem_ack forever.
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          timeout_err
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          grant_if, grant_dm, acc_done;
  logic          in_acc, ack_ok, tmo_hit;
  logic [DW-1:0] rd_data;
  logic [SW-1:0] starve_q;

  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;
  logic          if_ready_q, dm_ready_q;

  assign in_acc  = (state_q == IF_ACC) || (state_q == DM_ACC);
  // An ack only counts while a request is actually outstanding.
  assign ack_ok  = mem_ack & mem_req_q;
  // A timed-out access returns zero, which decodes as a NOP for fetches.
  assign rd_data = ack_ok ? mem_rdata : '0;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_err_q;

  // Fires on the TIMEOUT-th access cycle that went by without an ack.
  assign tmo_hit = in_acc & ~ack_ok & (tmo_cnt_q == TMO_LAST);

  // Watchdog counter per access and the sticky error flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (grant_if || grant_dm) begin
        tmo_cnt_q <= '0;
      end else if (in_acc && !ack_ok) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      if (tmo_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration and sequencing: data wins ties unless the fetch is starved
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    acc_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req && (!if_req || (starve_q != STARVE_LIM))) begin
          grant_dm = 1'b1;
          state_d  = DM_ACC;
        end else if (if_req) begin
          grant_if = 1'b1;
          state_d  = IF_ACC;
        end
      end
      IF_ACC, DM_ACC: begin
        if (ack_ok || tmo_hit) begin
          acc_done = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory request launch/retire, read capture, ready pulses, starvation count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      starve_q    <= '0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if (grant_dm) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= dm_we;
        mem_addr_q  <= dm_addr;
        mem_wdata_q <= dm_wdata;
      end else if (grant_if) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= if_addr;
        mem_wdata_q <= '0;
      end else if (acc_done) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        if (state_q == DM_ACC) begin
          dm_ready_q <= 1'b1;
          // Stores leave the last load result untouched.
          if (!mem_we_q) begin
            dm_rdata_q <= rd_data;
          end
        end else begin
          if_ready_q <= 1'b1;
          if_rdata_q <= rd_data;
        end
      end
      if (grant_if) begin
        starve_q <= '0;
      end else if (grant_dm && if_req && (starve_q != STARVE_LIM)) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  assign stall     = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: expected memory grants and
// completions are queued when stimulus is issued and checked when the
// memory model sees a new request or a ready pulse appears.
module tb_unified_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        timeout_err;

  unified_mem_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ready   (if_ready),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_ready   (dm_ready),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic        dm;
    logic [31:0] data;
  } done_t;

  grant_t      grant_q[$];
  done_t       done_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          ack_delay = 0;
  int          last_len = 0;
  int          stall_low = 0;
  logic [31:0] exp_dm_rdata = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return a ^ 32'hC3C3_3C3C;
  endfunction

  task automatic exp_if(input logic [31:0] addr, input logic [31:0] data);
    grant_t g;
    done_t  d;
    g.we = 1'b0; g.addr = addr; g.wdata = '0;
    d.dm = 1'b0; d.data = data;
    grant_q.push_back(g);
    done_q.push_back(d);
  endtask

  task automatic exp_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    grant_t g;
    done_t  d;
    g.we = we; g.addr = addr; g.wdata = wdata;
    if (!we) exp_dm_rdata = mem_val(addr);
    d.dm = 1'b1; d.data = exp_dm_rdata;
    grant_q.push_back(g);
    done_q.push_back(d);
  endtask

  // Fetch requester: holds req until ready; returns cycles from request to ready.
  task automatic do_if(input logic [31:0] addr, output int lat);
    int t0;
    bit seen;
    seen = 1'b0;
    t0 = cyc;
    if_addr = addr;
    if_req = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (if_ready) begin
        seen = 1'b1;
        break;
      end
      if (!stall) stall_low++;
    end
    if (!seen) check_val("if_ready_wait", if_ready, 1);
    lat = cyc - t0;
    if_req = 1'b0;
  endtask

  // Data requester: keep=1 leaves dm_req high for a back-to-back access.
  task automatic do_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit keep);
    bit seen;
    seen = 1'b0;
    dm_we = we;
    dm_addr = addr;
    dm_wdata = wdata;
    dm_req = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (dm_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val("dm_ready_wait", dm_ready, 1);
    if (!keep) dm_req = 1'b0;
  endtask

  // Memory model: checks each new grant, checks operands hold, acks after ack_delay waits
  initial begin : mem_model
    int     waits;
    int     len;
    logic   prev_req;
    logic   h_we;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    grant_t g;
    waits = 0; len = 0; prev_req = 1'b0;
    h_we = 1'b0; h_addr = '0; h_wdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_req) begin
        if (!prev_req) begin
          len = 0;
          waits = 0;
          if (grant_q.size() == 0) begin
            check_val("grant_q_size", grant_q.size(), 1);
          end else begin
            g = grant_q.pop_front();
            check_val("grant_we", mem_we, g.we);
            check_val("grant_addr", mem_addr, g.addr);
            check_val("grant_wdata", mem_wdata, g.wdata);
          end
          h_we = mem_we; h_addr = mem_addr; h_wdata = mem_wdata;
        end else begin
          check_val("hold_we", mem_we, h_we);
          check_val("hold_addr", mem_addr, h_addr);
          check_val("hold_wdata", mem_wdata, h_wdata);
        end
        len++;
        if (waits == ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = mem_val(mem_addr);
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end
        waits++;
      end else begin
        if (prev_req) last_len = len;
        mem_ack = 1'b0;
        waits = 0;
      end
      prev_req = mem_req;
    end
  end

  // Completion monitor: pops the scoreboard on every ready pulse
  initial begin : ready_mon
    done_t d;
    forever begin
      @(negedge clock);
      if (if_ready || dm_ready) begin
        check_val("ready_excl", if_ready & dm_ready, 0);
        if (done_q.size() == 0) begin
          check_val("done_q_size", done_q.size(), 1);
        end else begin
          d = done_q.pop_front();
          check_val("done_port", dm_ready, d.dm);
          if (dm_ready) check_val("dm_rdata", dm_rdata, d.data);
          else          check_val("if_rdata", if_rdata, d.data);
          $display("txn t=%0t port=%s if_rdata=0x%08h dm_rdata=0x%08h expected=0x%08h",
                   $time, dm_ready ? "DM" : "IF", if_rdata, dm_rdata, d.data);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin : main
    int lat;
    repeat (3) @(negedge clock);
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    check_val("rst_if_rdata", if_rdata, 0);
    check_val("rst_dm_rdata", dm_rdata, 0);
    check_val("rst_if_ready", if_ready, 0);
    check_val("rst_dm_ready", dm_ready, 0);
    check_val("rst_timeout_err", timeout_err, 0);
    check_val("rst_stall", stall, 0);
    reset = 1'b1;
    @(negedge clock);

    // Single fetch, ack in first request cycle: minimum latency
    ack_delay = 0;
    exp_if(32'h0040_0000, 32'h2008_0005);
    do_if(32'h0040_0000, lat);
    check_val("if_latency", lat, 2);
    check_val("if_rdata_val", if_rdata, 32'h2008_0005);
    @(negedge clock);
    check_val("if_rdata_hold", if_rdata, 32'h2008_0005);

    // Simultaneous load and fetch: load first, stall held until fetch ready
    stall_low = 0;
    exp_dm(1'b0, 32'h1001_0000, 32'h0);
    exp_if(32'h0040_0004, mem_val(32'h0040_0004));
    fork
      do_dm(1'b0, 32'h1001_0000, 32'h0, 1'b0);
      do_if(32'h0040_0004, lat);
    join
    check_val("stall_until_if_ready", stall_low, 0);
    @(negedge clock);

    // Store with three wait states: request held four cycles, dm_rdata kept
    ack_delay = 3;
    exp_dm(1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
    do_dm(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0);
    repeat (2) @(negedge clock);
    check_val("store_req_len", last_len, 4);
    check_val("store_keeps_dm_rdata", dm_rdata, mem_val(32'h1001_0000));

    // Back-to-back stores against a waiting fetch: fetch after four stores
    ack_delay = 0;
    for (int k = 0; k < 4; k++) exp_dm(1'b1, 32'h1001_0100 + 32'(4 * k), 32'h1111_0000 + 32'(k));
    exp_if(32'h0040_0008, mem_val(32'h0040_0008));
    for (int k = 4; k < 6; k++) exp_dm(1'b1, 32'h1001_0100 + 32'(4 * k), 32'h1111_0000 + 32'(k));
    fork
      begin
        for (int k = 0; k < 6; k++)
          do_dm(1'b1, 32'h1001_0100 + 32'(4 * k), 32'h1111_0000 + 32'(k), k < 5);
      end
      do_if(32'h0040_0008, lat);
    join
    @(negedge clock);

    // Reset in the middle of a data access
    ack_delay = -1;
    begin
      grant_t g;
      g.we = 1'b0; g.addr = 32'h1001_0008; g.wdata = '0;
      grant_q.push_back(g);
    end
    dm_we = 1'b0; dm_addr = 32'h1001_0008; dm_wdata = '0; dm_req = 1'b1;
    repeat (3) @(negedge clock);
    check_val("pre_rst_mem_req", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    check_val("async_rst_mem_req", mem_req, 0);
    check_val("async_rst_mem_addr", mem_addr, 0);
    check_val("async_rst_dm_rdata", dm_rdata, 0);
    dm_req = 1'b0;
    exp_dm_rdata = '0;
    if_addr = 32'h0040_000C;
    if_req = 1'b1;
    @(negedge clock);
    check_val("rst_no_dm_ready", dm_ready, 0);
    exp_if(32'h0040_000C, mem_val(32'h0040_000C));
    ack_delay = 0;
    reset = 1'b1;
    do_if(32'h0040_000C, lat);
    check_val("post_rst_if_latency", lat, 2);
    @(negedge clock);

`ifdef ARB_TIMEOUT_EN
    // Fetch with no ack at all: watchdog completes it with a NOP
    check_val("pre_tmo_err", timeout_err, 0);
    ack_delay = -1;
    exp_if(32'h0040_0020, 32'h0);
    do_if(32'h0040_0020, lat);
    check_val("tmo_latency", lat, 256);
    repeat (2) @(negedge clock);
    check_val("tmo_req_len", last_len, 255);
    check_val("tmo_err_set", timeout_err, 1);
    repeat (5) @(negedge clock);
    check_val("tmo_err_sticky", timeout_err, 1);
    #2 reset = 1'b0;
    #1;
    check_val("tmo_err_rst", timeout_err, 0);
    @(negedge clock);
    reset = 1'b1;
    ack_delay = 0;
`else
    check_val("timeout_err_tied", timeout_err, 0);
`endif

    repeat (3) @(negedge clock);
    check_val("grant_q_empty", grant_q.size(), 0);
    check_val("done_q_empty", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
